// File: rtl/aes_ks_pkg.sv
// -----------------------------------------------------------------------------
// aes_ks_pkg
// Shared types, constants and helpers for the AES-128 round-key sequencer.
//   ks_state_e : controller state (KS_IDLE, KS_EMIT)
//   aes_word_t : one 32-bit key-schedule word
//   aes_key_t  : one 128-bit round key, w0 in [127:96]
//   RCON_INIT  : round constant used to derive rk1
//   xtime      : GF(2^8) multiply-by-two, steps Rcon between rounds
//   rot_word   : cyclic byte rotate left of a word
// -----------------------------------------------------------------------------
package aes_ks_pkg;

    typedef enum logic {KS_IDLE, KS_EMIT} ks_state_e;

    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_key_t;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_word_t rot_word(input aes_word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Forward AES S-box, purely combinational table lookup.
//   i_a : input byte
//   o_s : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_a,
    output logic [7:0] o_s
);

    // Row r of the table holds S(16r .. 16r+15), leftmost byte first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_s = SBOX[i_a];

endmodule

// File: rtl/aes_subword.sv
// -----------------------------------------------------------------------------
// aes_subword
// SubWord: applies the AES S-box to each byte of a 32-bit word.
// Purely combinational.
//   i_word : input word
//   o_word : substituted word, byte order preserved
// -----------------------------------------------------------------------------
module aes_subword
    import aes_ks_pkg::*;
(
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_a (i_word[8*g +: 8]),
            .o_s (o_word[8*g +: 8])
        );
    end

endmodule

// File: rtl/aes_round_key_seq.sv
// -----------------------------------------------------------------------------
// aes_round_key_seq
// Iterative AES-128 key schedule. After key_load it presents rk0..NUM_ROUNDS
// one at a time on a valid/ready interface and pulses done once the last key
// has been accepted. One expansion step happens per accepted key.
//   clk, rst  : clock, asynchronous active-high reset
//   key_load  : start a schedule from key_in (ignored while busy)
//   key_in    : cipher key, w0 in [127:96]
//   busy      : schedule in progress
//   rk_valid  : rk_data/rk_idx carry a round key
//   rk_ready  : consumer accepts the key this cycle
//   rk_data   : current round key
//   rk_idx    : round number of rk_data
//   done      : one-cycle pulse after the final key is accepted
// -----------------------------------------------------------------------------
module aes_round_key_seq
    import aes_ks_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int IDX_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_load,
    input  logic [127:0]     key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [IDX_W-1:0] rk_idx,
    output logic             done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS);

    ks_state_e        r_state, w_next_state;
    aes_key_t         r_rk_data;
    logic [IDX_W-1:0] r_rk_idx;
    logic [7:0]       r_rcon;
    logic             r_done;

    logic             w_load, w_step, w_last;
    aes_word_t        w_sub, w_t;
    aes_word_t        w_w0, w_w1, w_w2, w_w3;
    aes_key_t         w_next_key;

    // Next round key, derived combinationally from the registered key.
    aes_subword u_subword (
        .i_word (rot_word(r_rk_data[31:0])),
        .o_word (w_sub)
    );

    assign w_t        = w_sub ^ {r_rcon, 24'h0};
    assign w_w0       = r_rk_data[127:96] ^ w_t;
    assign w_w1       = r_rk_data[95:64]  ^ w_w0;
    assign w_w2       = r_rk_data[63:32]  ^ w_w1;
    assign w_w3       = r_rk_data[31:0]   ^ w_w2;
    assign w_next_key = {w_w0, w_w1, w_w2, w_w3};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= KS_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        busy         = 1'b0;
        rk_valid     = 1'b0;
        case (r_state)
            KS_IDLE: begin
                if (key_load) begin
                    w_next_state = KS_EMIT;
                    w_load       = 1'b1;
                end
            end
            KS_EMIT: begin
                busy     = 1'b1;
                rk_valid = 1'b1;
                if (rk_ready) begin
                    if (r_rk_idx == LAST_IDX) begin
                        w_next_state = KS_IDLE;
                        w_last       = 1'b1;
                    end else begin
                        w_step = 1'b1;
                    end
                end
            end
            default: w_next_state = KS_IDLE;
        endcase
    end

    // Data path only moves on load or an accepted non-final key, so stalls
    // hold everything and the last key stays visible after done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rk_data <= '0;
            r_rk_idx  <= '0;
            r_rcon    <= RCON_INIT;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_rk_data <= key_in;
                r_rk_idx  <= '0;
                r_rcon    <= RCON_INIT;
            end else if (w_step) begin
                r_rk_data <= w_next_key;
                r_rk_idx  <= r_rk_idx + IDX_W'(1);
                r_rcon    <= xtime(r_rcon);
            end
        end
    end

    assign rk_data = r_rk_data;
    assign rk_idx  = r_rk_idx;
    assign done    = r_done;

endmodule

// File: tb/tb_aes_round_key_seq.sv
module tb_aes_round_key_seq;

    localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A1_RK1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A1_RK3   = 128'h3d80477d4716fe3e1e237e446d7a883b;
    localparam logic [127:0] A1_RK10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;

    logic         clk, rst;
    logic         key_load, rk_ready;
    logic [127:0] key_in;
    logic         busy, rk_valid, done;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    logic         key_load3, rk_ready3;
    logic [127:0] key_in3;
    logic         busy3, rk_valid3, done3;
    logic [127:0] rk_data3;
    logic [3:0]   rk_idx3;

    int n_run  = 0;
    int n_fail = 0;

    logic [7:0]   sbox_t [0:255];
    logic [7:0]   rcon_t [0:9];
    logic [127:0] ks     [0:10];
    logic [127:0] got    [0:10];

    aes_round_key_seq #(.NUM_ROUNDS(10), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_data(rk_data), .rk_idx(rk_idx), .done(done)
    );

    aes_round_key_seq #(.NUM_ROUNDS(3), .IDX_W(4)) dut3 (
        .clk(clk), .rst(rst), .key_load(key_load3), .key_in(key_in3),
        .busy(busy3), .rk_valid(rk_valid3), .rk_ready(rk_ready3),
        .rk_data(rk_data3), .rk_idx(rk_idx3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
        n_run++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got_v, exp_v);
        end
    endtask

    // ---------------- reference model: FIPS-197 from first principles -------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [7:0] r = b;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic build_ks(input logic [127:0] key, input int nr);
        logic [31:0] w [0:43];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ks[r] = '0;
        for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers --------------------------------------
    // Called at a negedge; returns at the negedge where rk0 should be visible.
    task automatic load(input logic [127:0] k);
        key_in   = k;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Walks one whole schedule and returns at the negedge of the done cycle.
    task automatic expect_sched(input int nr, input bit rnd, input int inj_idx, input bit chk_lat);
        int          hs    = 0;
        int          cyc   = 0;
        bit          stall = 1'b0;
        bit          injd  = 1'b0;
        logic [127:0] pd   = '0;
        logic [3:0]   pi   = '0;
        while (hs <= nr && cyc < 400) begin
            key_load = 1'b0;
            if (!rk_valid || !busy) begin
                chk("valid_busy_hi", 128'({busy, rk_valid}), 128'(3));
                break;
            end
            if (stall) begin
                chk("stall_data", rk_data, pd);
                chk("stall_idx", 128'(rk_idx), 128'(pi));
            end
            if (inj_idx >= 0 && !injd && rk_idx == 4'(inj_idx)) begin
                key_load = 1'b1;
                key_in   = {$urandom, $urandom, $urandom, $urandom};
                injd     = 1'b1;
            end
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_ready) begin
                chk("rk_idx", 128'(rk_idx), 128'(hs));
                chk("rk_data", rk_data, ks[hs]);
                got[hs] = rk_data;
                hs++;
            end
            stall = !rk_ready;
            pd    = rk_data;
            pi    = rk_idx;
            @(negedge clk);
            cyc++;
        end
        key_load = 1'b0;
        chk("handshakes", 128'(hs), 128'(nr + 1));
        if (chk_lat) chk("latency", 128'(cyc), 128'(nr + 1));
        chk("done_pulse", 128'(done), 128'(1));
        chk("done_valid", 128'(rk_valid), 128'(0));
        chk("done_busy", 128'(busy), 128'(0));
        chk("done_hold", rk_data, ks[nr]);
    endtask

    task automatic finish_idle();
        @(negedge clk);
        chk("done_once", 128'(done), 128'(0));
        chk("idle_valid", 128'(rk_valid), 128'(0));
    endtask

    // ---------------- main sequence -----------------------------------------
    initial begin
        int c;
        logic [127:0] key_b;
        rcon_t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

        rst = 1'b1; key_load = 1'b0; key_in = '0; rk_ready = 1'b0;
        key_load3 = 1'b0; key_in3 = '0; rk_ready3 = 1'b1;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_idx", 128'(rk_idx), 128'(0));
        chk("rst_data", rk_data, 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: A.1 key, always ready
        build_ks(KEY_A1, 10);
        load(KEY_A1);
        expect_sched(10, 1'b0, -1, 1'b1);
        chk("a1_rk0", got[0], KEY_A1);
        chk("a1_rk1", got[1], A1_RK1);
        chk("a1_rk10", got[10], A1_RK10);
        finish_idle();

        // 2: all-zero key
        build_ks('0, 10);
        load('0);
        expect_sched(10, 1'b0, -1, 1'b1);
        chk("zero_rk1", got[1], ZERO_RK1);
        finish_idle();

        // 3: A.1 key with random back-pressure, a few passes
        build_ks(KEY_A1, 10);
        for (int p = 0; p < 3; p++) begin
            load(KEY_A1);
            expect_sched(10, 1'b1, -1, 1'b0);
            chk("bp_rk10", got[10], A1_RK10);
            finish_idle();
        end

        // random keys under back-pressure
        for (int p = 0; p < 3; p++) begin
            key_b = {$urandom, $urandom, $urandom, $urandom};
            build_ks(key_b, 10);
            load(key_b);
            expect_sched(10, 1'b1, -1, 1'b0);
            finish_idle();
        end

        // 4: key_load while busy ignored; key_load in done cycle accepted
        build_ks(KEY_A1, 10);
        load(KEY_A1);
        expect_sched(10, 1'b1, 4, 1'b0);
        chk("inj_rk10", got[10], A1_RK10);
        key_b    = {$urandom, $urandom, $urandom, $urandom};
        key_in   = key_b;
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
        chk("reload_done_once", 128'(done), 128'(0));
        chk("reload_valid", 128'(rk_valid), 128'(1));
        chk("reload_idx", 128'(rk_idx), 128'(0));
        chk("reload_rk0", rk_data, key_b);

        // 5: asynchronous reset mid-cycle at rk_idx 6
        rk_ready = 1'b1;
        c = 0;
        while (rk_idx != 4'd6 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("reach_idx6", 128'(rk_idx), 128'(6));
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_valid", 128'(rk_valid), 128'(0));
        chk("arst_idx", 128'(rk_idx), 128'(0));
        @(negedge clk);
        chk("arst_no_done", 128'(done), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 128'(done), 128'(0));
        chk("post_rst_valid", 128'(rk_valid), 128'(0));
        build_ks(KEY_A1, 10);
        load(KEY_A1);
        chk("fresh_rk0", rk_data, KEY_A1);
        expect_sched(10, 1'b0, -1, 1'b1);
        finish_idle();

        // 6: NUM_ROUNDS=3 build
        build_ks(KEY_A1, 3);
        key_in3   = KEY_A1;
        key_load3 = 1'b1;
        @(negedge clk);
        key_load3 = 1'b0;
        for (int r = 0; r <= 3; r++) begin
            chk("nr3_valid", 128'(rk_valid3), 128'(1));
            chk("nr3_idx", 128'(rk_idx3), 128'(r));
            chk("nr3_data", rk_data3, ks[r]);
            if (r == 3) chk("nr3_rk3", rk_data3, A1_RK3);
            @(negedge clk);
        end
        chk("nr3_done", 128'(done3), 128'(1));
        chk("nr3_idle", 128'(rk_valid3), 128'(0));
        @(negedge clk);
        chk("nr3_done_once", 128'(done3), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_key_seq.md
Name: aes_round_key_seq

Overview:
Iterative AES-128 key-schedule stage. It sits directly upstream of the aes_cipher_top round datapath on the same clock tree leaf.
- Accepts a 128-bit cipher key and emits round keys 0..NUM_ROUNDS, one per handshake.
- The downstream round register consumes each key over a valid/ready interface.
- Replaces the free-running key expansion with a flow-controlled, back-pressurable producer.

Parameters:
- NUM_ROUNDS, 10, number of expanded round keys after rk0. Legal range 1..10, bounded by the Rcon table.
- IDX_W, 4, width of the round index output. Must satisfy 2**IDX_W > NUM_ROUNDS.

Ports:
- clk  input  1  clock; single clock domain.
- rst  input  1  reset, asynchronous, active-high.
- key_load  input  1  one-cycle request to start a schedule from key_in.
- key_in  input  128  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
- busy  output  1  high while a schedule is in progress.
- rk_valid  output  1  rk_data/rk_idx hold a valid round key.
- rk_ready  input  1  consumer accepts the key when rk_valid & rk_ready.
- rk_data  output  128  current round key, same word order as key_in.
- rk_idx  output  IDX_W  round number of rk_data, 0..NUM_ROUNDS.
- done  output  1  one-cycle pulse after the last key is accepted.

Behaviour:
- Reset: rst asserted at any time immediately forces state IDLE. busy, rk_valid, done, rk_idx = 0; rk_data = 0; Rcon register = 8'h01. Any schedule in progress is abandoned with no done pulse.
- States:
  - IDLE: busy=0, rk_valid=0.
  - EMIT: busy=1, rk_valid=1.
- IDLE -> EMIT on key_load.
  - Cycle N key_load: at N+1, rk_data = key_in sampled at N, rk_idx = 0, rk_valid = 1, Rcon = 8'h01.
- EMIT, handshake with rk_idx < NUM_ROUNDS:
  - Next cycle: rk_data = expand(rk_data, Rcon), rk_idx + 1, Rcon = xtime(Rcon).
  - rk_valid stays 1.
- EMIT, handshake with rk_idx == NUM_ROUNDS:
  - Next cycle: state IDLE, rk_valid = 0, done = 1 for exactly one cycle.
  - rk_data retains its last value.
- Back-pressure: with rk_valid=1 and rk_ready=0, rk_data, rk_idx and Rcon hold stable. No value may change while valid is pending.
- Throughput and latency: with rk_ready tied high, rk0..rk10 appear on 11 consecutive cycles N+1..N+11, and done is asserted at N+12.
- Expansion, with w0..w3 the current words:
  - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}
  - w0' = w0^t
  - w1' = w1^w0'
  - w2' = w2^w1'
  - w3' = w3^w2'
- xtime: {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00). This yields the sequence 01,02,04,08,10,20,40,80,1b,36.
- key_load while busy is ignored; the running schedule is unaffected.
- key_load in the same cycle as the final handshake is also ignored. The done cycle is IDLE, so a key_load during done is accepted normally.
- SubWord is combinational from the registered w3. No S-box output is registered.

Decomposition:
- Package aes_ks_pkg holds:
  - state enum {KS_IDLE, KS_EMIT}
  - typedef aes_word_t (logic [31:0]) and aes_key_t (logic [127:0])
  - constant RCON_INIT = 8'h01
  - function xtime, function rot_word
- Sub-module aes_subword: four instances of the existing aes_sbox, 32-bit in, 32-bit out, purely combinational.
- The controller, index counter and Rcon register stay in aes_round_key_seq.

Test Plan:
1. FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1:
   - rk0 = key, rk1 = a0fafe1788542cb123a339392a6c7605, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
   - done at load+12.
2. All-zero key, rk_ready=1: rk1 = 62636363626363636263636362636363; rk_idx steps 0..10 with no gaps.
3. Random rk_ready (~50%) with the A.1 key:
   - Identical key sequence to scenario 1.
   - rk_data/rk_idx stable whenever valid & !ready.
   - Exactly 11 handshakes, then one done pulse.
4. key_load pulsed at rk_idx=4 with a different key_in: ignored; sequence continues to the A.1 rk10. Then key_load during the done cycle starts a new schedule at rk_idx=0.
5. rst asserted asynchronously mid-cycle at rk_idx=6:
   - busy/rk_valid/rk_idx drop to 0 before the next clk edge; no done pulse.
   - A subsequent key_load produces a correct fresh rk0.
6. NUM_ROUNDS=3 build, A.1 key: keys rk0..rk3 only, rk3 = 3d80477d4716fe3e1e237e446d7a883b, done after the 4th handshake.
